note_sequencer: RTL
===================

# note_sequencer

Song sequencer that reads the play/pause flag from the play/pause FSM and turns it into audible output. It walks an internal song table, holds each note for its programmed number of beats and drives a square-wave `buzzer`. When the flag drops it freezes at the exact cycle position and resumes from there when the flag rises again. It sits between the play/pause FSM and the board buzzer pin.

## Interface
- `TICK_DIV`, 4: clock cycles per beat (≥2)
- `SONG_LEN`, 8: number of song entries (≥2)
- `BASE`, 1: tone scale; half-period of note code n is BASE*(8-n) cycles
- `LOOP`, 0: 1 = wrap to entry 0 after the last entry; 0 = stop in DONE
- `clk`  input  1  system clock, all logic on rising edge
- `reset`  input  1  synchronous, active-high; overrides every other input
- `play`  input  1  play/pause level from the play/pause FSM (1 = play)
- `buzzer`  output  1  square-wave tone output
- `note`  output  3  code of the current entry (0 = rest, 1..7 = tones)
- `note_idx`  output  $clog2(SONG_LEN)  index of the current entry
- `tocando`  output  1  high in PLAY state only
- `fim`  output  1  high in DONE state only

## Operation
- Song table is internal and combinational, indexed by i:
  - note(i) = (i mod 7)+1, except i = 3, which is forced to 0 (rest)
  - dur(i) = (i mod 4)+1 beats
- States:
  - IDLE: entered after reset. `play`=1 → PLAY with idx=0 and all counters 0.
  - PLAY: tick counter counts 0..TICK_DIV-1. Each wrap advances the beat counter.
    - When a wrap occurs with beat = dur(idx)-1, the note ends: idx+1, beat=0, tone counter=0, buzzer=0.
    - At idx = SONG_LEN-1 the note end goes to idx=0 if LOOP=1; otherwise the block enters DONE.
    - `play`=0 → PAUSE. Takes priority over a note end in the same cycle: nothing advances.
  - PAUSE: tick, beat, tone counters and idx are frozen; buzzer is forced 0. `play`=1 → PLAY, continuing from the frozen counts.
  - DONE: buzzer=0, idx holds SONG_LEN-1. `play`=0 → IDLE, so a new press restarts from entry 0. `play` held at 1 stays in DONE.
- Tone generation runs in PLAY only, and only when note ≠ 0:
  - Tone counter counts 0..BASE*(8-note)-1; on wrap, `buzzer` toggles.
  - When note = 0, buzzer stays 0 and the tone counter stays 0.
- Width rules:
  - Tick counter is $clog2(TICK_DIV) bits.
  - Beat counter is 2 bits (dur ≤ 4).
  - Tone counter is $clog2(8*BASE) bits.
  - All compares are unsigned. idx increments modulo SONG_LEN.

## Timing
- Reset values: state IDLE, `buzzer`=0, `note_idx`=0, `tocando`=0, `fim`=0. `note` = note(0) = 1. All internal counters 0.
- Reset asserted mid-song (any state) takes effect on the next rising edge. The block returns to IDLE with the reset values above.
- `play` is sampled on edge k; `tocando` rises after edge k. The first tick is counted on edge k+1.
- In uninterrupted PLAY, entry i lasts exactly dur(i)*TICK_DIV cycles. `note_idx` changes on the edge that completes the last tick.
- First buzzer toggle of a tonal note occurs BASE*(8-note) cycles after the note starts.
- A pause of any length adds exactly that many cycles to the current note. Buzzer phase resumes from the frozen tone count.
- All outputs are registered or decoded from registered state. There are no combinational paths from `play` to any output.

## Test plan
- Reset, then `play`=1 held → `tocando`=1 one cycle later. `note_idx` follows 0,1,2,… with durations 4, 8, 12, 16, 4, 8, 12, 16 cycles. After 80 cycles `fim`=1, `tocando`=0, `note_idx`=7.
- Entry 2 (note 3, half-period 5) → buzzer toggles exactly at cycles 5 and 10 of the note, then resets to 0 at the note boundary. Entry 3 (rest) → buzzer constant 0 for 16 cycles.
- Play for 6 cycles into entry 1, `play`=0 for 20 cycles, then `play`=1 → `note_idx` stays 1, buzzer 0 during the pause. Entry 1 ends 2 cycles after resume.
- `play` drops on the same edge a note would end → idx does not advance. After resume, the advance happens one cycle later.
- LOOP=1, `play` held → after the 80-cycle song `note_idx` wraps 7→0, `fim` never asserts. LOOP=0, DONE, then `play` 0→1 → IDLE, then restart at idx 0.
- Assert `reset` for 1 cycle during PAUSE at idx 5 → next cycle all outputs at their reset values. A subsequent `play`=1 starts from idx 0.

Source files
------------

// File: rtl/note_sequencer.sv
// Song sequencer: walks an internal note table, holds each note for its
// beat count and drives a square-wave buzzer; pauses freeze the position.
module note_sequencer #(
  parameter int TICK_DIV = 4,
  parameter int SONG_LEN = 8,
  parameter int BASE     = 1,
  parameter int LOOP     = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        play,
  output logic                        buzzer,
  output logic [2:0]                  note,
  output logic [$clog2(SONG_LEN)-1:0] note_idx,
  output logic                        tocando,
  output logic                        fim
);

  localparam int IW  = $clog2(SONG_LEN);
  localparam int TW  = $clog2(TICK_DIV);
  localparam int TNW = $clog2(8 * BASE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IW-1:0] LAST  = IW'(SONG_LEN - 1);
  localparam logic [TW-1:0] T_TOP = TW'(TICK_DIV - 1);

  logic [1:0]     state;
  logic [IW-1:0]  idx;
  logic [TW-1:0]  tick;
  logic [1:0]     beat;
  logic [TNW-1:0] tone;
  logic           phase;

  logic [2:0]     note_w;
  logic [1:0]     beat_top;
  logic [TNW-1:0] tone_top;
  logic           tick_wrap;
  logic           note_end;

  function automatic logic [2:0] note_of(input logic [IW-1:0] i);
    if (int'(i) == 3) return 3'd0;
    return 3'((int'(i) % 7) + 1);
  endfunction

  function automatic logic [1:0] beat_top_of(input logic [IW-1:0] i);
    return 2'(int'(i) % 4);
  endfunction

  // Song table lookup and end-of-tick / end-of-note decode
  always_comb begin
    note_w    = note_of(idx);
    beat_top  = beat_top_of(idx);
    tone_top  = TNW'(BASE * (8 - int'(note_w)) - 1);
    tick_wrap = (tick == T_TOP);
    note_end  = tick_wrap && (beat == beat_top);
  end

  // Sequencer state, position counters and tone phase
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      tick  <= '0;
      beat  <= '0;
      tone  <= '0;
      phase <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (play) begin
            state <= S_PLAY;
            idx   <= '0;
            tick  <= '0;
            beat  <= '0;
            tone  <= '0;
            phase <= 1'b0;
          end
        end
        S_PLAY: begin
          if (!play) begin
            state <= S_PAUSE;
          end else if (note_end) begin
            tick  <= '0;
            beat  <= '0;
            tone  <= '0;
            phase <= 1'b0;
            if (idx == LAST) begin
              if (LOOP != 0) idx <= '0;
              else state <= S_DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            if (tick_wrap) begin
              tick <= '0;
              beat <= beat + 2'd1;
            end else begin
              tick <= tick + 1'b1;
            end
            if (note_w != 3'd0) begin
              if (tone == tone_top) begin
                tone  <= '0;
                phase <= ~phase;
              end else begin
                tone <= tone + 1'b1;
              end
            end
          end
        end
        S_PAUSE: begin
          if (play) state <= S_PLAY;
        end
        S_DONE: begin
          if (!play) begin
            state <= S_IDLE;
            idx   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    buzzer   = phase && (state == S_PLAY);
    note     = note_w;
    note_idx = idx;
    tocando  = (state == S_PLAY);
    fim      = (state == S_DONE);
  end

endmodule
